// File: rtl/xbar_pkg.sv
// Shared types for the crossbar master port: FSM encoding and width helpers.
package xbar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } xbar_state_t;

  localparam int XBAR_NS_MIN = 2;
  localparam int XBAR_NS_MAX = 16;

  function automatic int xbar_idx_w(input int ns);
    return (ns > 1) ? $clog2(ns) : 1;
  endfunction

endpackage

// File: rtl/xbar_addr_dec.sv
// Slave-index decode: index field, one-hot select and range flag.
module xbar_addr_dec
  import xbar_pkg::*;
#(
  parameter int NS      = 4,
  parameter int AW      = 12,
  parameter int SLV_LSB = 0,
  parameter int IW      = xbar_idx_w(NS)
) (
  input  logic [AW-1:0] addr,
  output logic [IW-1:0] idx,
  output logic [NS-1:0] onehot,
  output logic          in_range
);

  logic unused_addr;

  assign idx         = addr[SLV_LSB +: IW];
  assign in_range    = 32'(idx) < NS;
  assign unused_addr = ^addr;

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NS; i++) begin
      onehot[i] = in_range && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/xbar_master_port.sv
// Crossbar master port: routes one request to a slave and returns its ack.
// Optional ack-wait timeout is enabled by defining XBAR_MST_TIMEOUT_EN.
module xbar_master_port
  import xbar_pkg::*;
#(
  parameter int NS      = 4,
  parameter int CMD_W   = 1,
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int SW      = 4,
  parameter int SLV_LSB = 0,
  parameter int TIMEOUT = 256
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iMstReq,
  input  logic [CMD_W-1:0] iMstCmd,
  input  logic [AW-1:0]    iMstAddr,
  input  logic [SW-1:0]    iMstSel,
  input  logic [DW-1:0]    iMstWData,
  output logic             oMstAck,
  output logic [DW-1:0]    oMstRData,
  output logic             oMstErr,
  output logic             oBusy,
  output logic [NS-1:0]    oSlvReq,
  output logic [CMD_W-1:0] oSlvCmd,
  output logic [AW-1:0]    oSlvAddr,
  output logic [SW-1:0]    oSlvSel,
  output logic [DW-1:0]    oSlvWData,
  input  logic [NS-1:0]    iSlvAck,
  input  logic [NS*DW-1:0] iSlvRData
);

  localparam int IW = xbar_idx_w(NS);

  xbar_state_t   state_q, state_d;
  logic [IW-1:0] idx, idx_q;
  logic [NS-1:0] onehot;
  logic          in_range;
  logic          sel_ack;
  logic          tmo;

  xbar_addr_dec #(
    .NS      (NS),
    .AW      (AW),
    .SLV_LSB (SLV_LSB),
    .IW      (IW)
  ) u_dec (
    .addr     (iMstAddr),
    .idx      (idx),
    .onehot   (onehot),
    .in_range (in_range)
  );

  // oSlvReq is one-hot on idx_q, so masking avoids a second decode
  assign sel_ack = |(iSlvAck & oSlvReq);

`ifdef XBAR_MST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      tmo_cnt <= '0;
    end else if (state_q != WAIT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo = (state_q == WAIT) && (tmo_cnt == CW'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;

  assign tmo = 1'b0;
`endif

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (iMstReq) state_d = in_range ? WAIT : RESP;
      WAIT: if (sel_ack || tmo) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      idx_q     <= '0;
      oSlvReq   <= '0;
      oSlvCmd   <= '0;
      oSlvAddr  <= '0;
      oSlvSel   <= '0;
      oSlvWData <= '0;
      oMstErr   <= 1'b0;
      oMstRData <= '0;
    end else begin
      unique case (1'b1)
        (state_q == IDLE) && iMstReq: begin
          idx_q     <= idx;
          oSlvReq   <= onehot;
          oSlvCmd   <= iMstCmd;
          oSlvAddr  <= iMstAddr;
          oSlvSel   <= iMstSel;
          oSlvWData <= iMstWData;
          oMstErr   <= !in_range;
          oMstRData <= '0;
        end
        // ack outranks a timeout landing in the same cycle
        (state_q == WAIT) && sel_ack: begin
          oSlvReq   <= '0;
          oMstErr   <= 1'b0;
          oMstRData <= iSlvRData[int'(idx_q)*DW +: DW];
        end
        (state_q == WAIT) && tmo: begin
          oSlvReq   <= '0;
          oMstErr   <= 1'b1;
          oMstRData <= '0;
        end
        default: ;
      endcase
    end
  end

  assign oMstAck = (state_q == RESP);
  assign oBusy   = (state_q != IDLE);

endmodule

// File: tb/tb_xbar_master_port.sv
// Directed + random transactions against a transaction-level response model.
module tb_xbar_master_port;

  localparam int NS_T  = 5;
  localparam int TMO_T = 8;
`ifdef XBAR_MST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iMstReq;
  logic [0:0]    iMstCmd;
  logic [11:0]   iMstAddr;
  logic [3:0]    iMstSel;
  logic [31:0]   iMstWData;
  logic          oMstAck;
  logic [31:0]   oMstRData;
  logic          oMstErr;
  logic          oBusy;
  logic [4:0]    oSlvReq;
  logic [0:0]    oSlvCmd;
  logic [11:0]   oSlvAddr;
  logic [3:0]    oSlvSel;
  logic [31:0]   oSlvWData;
  logic [4:0]    iSlvAck;
  logic [159:0]  iSlvRData;

  int total = 0;
  int bad   = 0;

  xbar_master_port #(
    .NS      (NS_T),
    .CMD_W   (1),
    .AW      (12),
    .DW      (32),
    .SW      (4),
    .SLV_LSB (0),
    .TIMEOUT (TMO_T)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iMstReq   (iMstReq),
    .iMstCmd   (iMstCmd),
    .iMstAddr  (iMstAddr),
    .iMstSel   (iMstSel),
    .iMstWData (iMstWData),
    .oMstAck   (oMstAck),
    .oMstRData (oMstRData),
    .oMstErr   (oMstErr),
    .oBusy     (oBusy),
    .oSlvReq   (oSlvReq),
    .oSlvCmd   (oSlvCmd),
    .oSlvAddr  (oSlvAddr),
    .oSlvSel   (oSlvSel),
    .oSlvWData (oSlvWData),
    .iSlvAck   (iSlvAck),
    .iSlvRData (iSlvRData)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // delay = WAIT cycles before the selected slave acks
  task automatic run_txn(input logic [11:0] addr,
                         input logic cmd,
                         input int delay,
                         input bit spur);
    int          idx, cyc, wait_n, exp_lat, exp_reqs;
    bit          in_rng, hit_to, exp_err, done;
    bit          oh_bad, fld_bad, busy_bad;
    logic [31:0] sdata, exp_data, wd;
    logic [3:0]  sel;
    logic [4:0]  exp_oh;

    idx      = int'(addr[2:0]);
    in_rng   = idx < NS_T;
    hit_to   = TO_EN && in_rng && (delay >= TMO_T);
    exp_err  = !in_rng || hit_to;
    sdata    = $urandom;
    exp_data = exp_err ? 32'h0 : sdata;
    exp_lat  = !in_rng ? 1 : (hit_to ? TMO_T + 1 : delay + 2);
    exp_reqs = !in_rng ? 0 : (hit_to ? TMO_T : delay + 1);
    exp_oh   = in_rng ? (5'd1 << idx) : 5'd0;

    @(negedge iClk);
    sel       = 4'($urandom);
    wd        = $urandom;
    iMstReq   = 1'b1;
    iMstCmd   = cmd;
    iMstAddr  = addr;
    iMstSel   = sel;
    iMstWData = wd;
    iSlvAck   = '0;
    cyc       = 0;
    wait_n    = 0;
    done      = 1'b0;
    oh_bad    = 1'b0;
    fld_bad   = 1'b0;
    busy_bad  = 1'b0;

    while (!done && cyc < 200) begin
      @(negedge iClk);
      cyc++;
      if (oMstAck === 1'b1) done = 1'b1;
      if (oBusy !== 1'b1) busy_bad = 1'b1;
      iMstCmd   = 1'($urandom);
      iMstAddr  = 12'($urandom);
      iMstSel   = 4'($urandom);
      iMstWData = $urandom;
      iSlvRData = {$urandom, $urandom, $urandom, $urandom, $urandom};
      iSlvAck   = spur ? (5'($urandom) & ~exp_oh) : 5'd0;
      if (oSlvReq !== 5'd0) begin
        if (oSlvReq !== exp_oh) oh_bad = 1'b1;
        if ({oSlvCmd, oSlvAddr, oSlvSel, oSlvWData} !== {cmd, addr, sel, wd})
          fld_bad = 1'b1;
        if (wait_n == delay) begin
          iSlvAck[idx]            = 1'b1;
          iSlvRData[idx*32 +: 32] = sdata;
        end
        wait_n++;
      end
    end

    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("err", 64'(oMstErr), 64'(exp_err));
    chk("rdata", 64'(oMstRData), 64'(exp_data));
    chk("req_cycles", 64'(wait_n), 64'(exp_reqs));
    chk("onehot", 64'(oh_bad), 64'd0);
    chk("fields", 64'(fld_bad), 64'd0);
    chk("busy", 64'(busy_bad), 64'd0);

    iMstReq = 1'b0;
    iSlvAck = '0;
    @(negedge iClk);
    chk("ack_once", 64'(oMstAck), 64'd0);
    chk("idle", 64'(oBusy), 64'd0);
  endtask

  initial begin
    bit saw_ack;

    iRst      = 1'b1;
    iMstReq   = 1'b0;
    iMstCmd   = '0;
    iMstAddr  = '0;
    iMstSel   = '0;
    iMstWData = '0;
    iSlvAck   = '0;
    iSlvRData = '0;
    repeat (2) @(negedge iClk);
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_req", 64'(oSlvReq), 64'd0);
    chk("rst_ack", 64'(oMstAck), 64'd0);
    chk("rst_err", 64'(oMstErr), 64'd0);
    chk("rst_rdata", 64'(oMstRData), 64'd0);
    chk("rst_addr", 64'(oSlvAddr), 64'd0);
    iRst = 1'b0;

    run_txn(12'h002, 1'b0, 0, 1'b0);
    run_txn(12'h003, 1'b1, 5, 1'b1);
    run_txn(12'h005, 1'b0, 0, 1'b0);
    run_txn(12'h007, 1'b1, 0, 1'b1);
    run_txn(12'hA84, 1'b0, 1, 1'b1);

`ifdef XBAR_MST_TIMEOUT_EN
    run_txn(12'h001, 1'b0, 100, 1'b1);
    run_txn(12'h001, 1'b0, TMO_T - 1, 1'b1);
    run_txn(12'h000, 1'b1, TMO_T - 2, 1'b0);
`else
    run_txn(12'h001, 1'b0, 20, 1'b1);
`endif

    @(negedge iClk);
    iMstReq  = 1'b1;
    iMstCmd  = 1'b0;
    iMstAddr = 12'h001;
    @(negedge iClk);
    chk("pre_rst_req", 64'(oSlvReq), 64'h2);
    @(negedge iClk);
    iRst = 1'b1;
    #1;
    chk("mid_rst_req", 64'(oSlvReq), 64'd0);
    chk("mid_rst_busy", 64'(oBusy), 64'd0);
    iMstReq = 1'b0;
    @(negedge iClk);
    iRst    = 1'b0;
    saw_ack = 1'b0;
    repeat (6) begin
      @(negedge iClk);
      if (oMstAck === 1'b1) saw_ack = 1'b1;
    end
    chk("no_ack_after_rst", 64'(saw_ack), 64'd0);
    run_txn(12'h001, 1'b0, 2, 1'b0);

    for (int n = 0; n < 24; n++) begin
      run_txn(12'($urandom), 1'($urandom),
              int'($urandom_range(0, TO_EN ? 11 : 6)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
